// File: rtl/uart_txer_if.sv
// Byte-write and serial-line signal bundle for the uart_txer transmit stage.
// The master writes bytes and observes the line; the slave is the transmitter.
interface uart_txer_if;
   logic [7:0] data_in;
   logic       en_data_in;
   logic       full;
   logic       TX;
   logic       tx_busy;
   logic       tx_done;

   modport master (
      output data_in,
      output en_data_in,
      input  full,
      input  TX,
      input  tx_busy,
      input  tx_done
   );

   modport slave (
      input  data_in,
      input  en_data_in,
      output full,
      output TX,
      output tx_busy,
      output tx_done
   );
endinterface

// File: rtl/uart_txer.sv
// 8N1 serial transmitter fed by a DEPTH-entry byte FIFO.
// Frames are sent back to back while the FIFO holds data, and every output is registered.
module uart_txer #(
   parameter int CLK_FREQ = 24000000,
   parameter int BAUD     = 4800,
   parameter int DEPTH    = 4
) (
   input  logic         clk,
   input  logic         rst,
   uart_txer_if.slave   bus
);

   localparam int BAUD_DIV = CLK_FREQ / BAUD;
   localparam int CNT_W    = $clog2(BAUD_DIV);
   localparam int PTR_W    = $clog2(DEPTH);

   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(BAUD_DIV - 2);
   localparam logic [PTR_W:0]   OCC_ZERO = (PTR_W + 1)'(0);
   localparam logic [PTR_W:0]   OCC_ONE  = (PTR_W + 1)'(1);
   localparam logic [PTR_W:0]   OCC_FULL = (PTR_W + 1)'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] baud_q, baud_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             tx_q, tx_d;
   logic             done_q, done_d;
   logic             full_q, full_d;
   logic             busy_q, busy_d;
   logic [PTR_W:0]   count_q, count_d;
   logic [PTR_W-1:0] rd_q, rd_d;
   logic [PTR_W-1:0] wr_q, wr_d;
   logic [7:0]       mem_q [DEPTH];

   logic             push_s;
   logic             pop_s;
   logic             baud_last_s;

   assign push_s      = bus.en_data_in & ~full_q;
   assign baud_last_s = (baud_q == CNT_LAST);

   // Frame sequencing: line level, bit timing and FIFO pops
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      tx_d    = tx_q;
      pop_s   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (count_q != OCC_ZERO) begin
               pop_s   = 1'b1;
               shift_d = mem_q[rd_q];
               baud_d  = CNT_ZERO;
               tx_d    = 1'b0;
               state_d = S_START;
            end else begin
               tx_d    = 1'b1;
            end
         end
         S_START: begin
            if (baud_last_s) begin
               baud_d  = CNT_ZERO;
               bit_d   = 3'd0;
               tx_d    = shift_q[0];
               state_d = S_DATA;
            end else begin
               baud_d  = baud_q + CNT_ONE;
            end
         end
         S_DATA: begin
            if (baud_last_s) begin
               baud_d = CNT_ZERO;
               if (bit_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = S_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
                  tx_d  = shift_q[bit_d];
               end
            end else begin
               baud_d = baud_q + CNT_ONE;
            end
         end
         S_STOP: begin
            tx_d = 1'b1;
            if (baud_last_s) begin
               baud_d = CNT_ZERO;
               // Chain straight into the next start bit so no idle gap appears
               if (count_q != OCC_ZERO) begin
                  pop_s   = 1'b1;
                  shift_d = mem_q[rd_q];
                  tx_d    = 1'b0;
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               baud_d = baud_q + CNT_ONE;
            end
         end
         default: begin
            tx_d    = 1'b1;
            state_d = S_IDLE;
         end
      endcase
   end

   // FIFO occupancy, pointers and registered status flags
   always_comb begin
      count_d = count_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + OCC_ONE;
         2'b01:   count_d = count_q - OCC_ONE;
         default: count_d = count_q;
      endcase
      if (push_s) begin
         wr_d = wr_q + PTR_ONE;
      end else begin
         wr_d = wr_q;
      end
      if (pop_s) begin
         rd_d = rd_q + PTR_ONE;
      end else begin
         rd_d = rd_q;
      end
      full_d = (count_d == OCC_FULL);
      busy_d = (state_d != S_IDLE) || (count_d != OCC_ZERO);
      // Registered tx_done lands on the final clock of the stop bit
      done_d = (state_q == S_STOP) && (baud_q == CNT_PRE);
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         baud_q  <= CNT_ZERO;
         bit_q   <= 3'd0;
         shift_q <= 8'h00;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
         full_q  <= 1'b0;
         busy_q  <= 1'b0;
         count_q <= OCC_ZERO;
         rd_q    <= '0;
         wr_q    <= '0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
         full_q  <= full_d;
         busy_q  <= busy_d;
         count_q <= count_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
      end
   end

   // FIFO storage; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_q[wr_q] <= bus.data_in;
      end
   end

   assign bus.TX      = tx_q;
   assign bus.full    = full_q;
   assign bus.tx_busy = busy_q;
   assign bus.tx_done = done_q;

endmodule
